ysyx_22050019_dmem_slave: RTL and testbench

- Memory-side responder for the core's data load/store path; the other end of the core's ren/wen/addr/wdata/mask memory interface.
- Wraps that interface in a valid/ready request/response handshake.
- Backs the handshake with an internal word-organised SRAM array and a programmable access latency.
- Lets the load/store path be exercised against a multi-cycle memory, ahead of moving from single-cycle to a multi-cycle/pipelined core.

---
 rtl/ysyx_22050019_dmem_slave_if.sv | 21 ++
 rtl/ysyx_22050019_dmem_slave.sv | 63 ++++++
 tb/tb_ysyx_22050019_dmem_slave.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_dmem_slave_if.sv
// ysyx_22050019_dmem_slave_if: valid/ready request/response bus for the data memory
interface ysyx_22050019_dmem_slave_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_22050019_dmem_slave.sv
// ysyx_22050019_dmem_slave: valid/ready data memory responder with programmable access latency
module ysyx_22050019_dmem_slave #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_22050019_dmem_slave_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        wen_q;
  logic [60:0] word_q, off;
  logic [63:0] wdata_q, rdata_q;
  logic [7:0]  wmask_q;
  logic        err_q, access, in_range;
  logic [63:0] mem [DEPTH];
  // decode works on word addresses, so byte-offset bits never reach the datapath
  assign off         = word_q - BASE_ADDR[63:3];
  assign in_range    = word_q >= BASE_ADDR[63:3] && off < 61'(DEPTH);
  assign access      = state == WAIT && cnt == 4'd0;
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = bus.req_valid ? WAIT : IDLE;
    else if (state == WAIT) state_nx = cnt == 4'd0 ? RESP : WAIT;
    else if (state == RESP) state_nx = bus.resp_ready ? IDLE : RESP;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        wen_q   <= bus.req_wen;
        word_q  <= bus.req_addr[63:3];
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (access) begin
        rdata_q <= (!wen_q && in_range) ? mem[off[AW-1:0]] : 64'd0;
        err_q   <= !in_range;
      end else if (state == RESP && bus.resp_ready) begin
        rdata_q <= 64'd0;
        err_q   <= 1'b0;
      end
    end
  end
  // array is deliberately left out of reset; rst only suppresses a pending write
  always_ff @(posedge clk)
    if (!rst && access && wen_q && in_range)
      for (int i = 0; i < 8; i++)
        if (wmask_q[i]) mem[off[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule

// File: tb/tb_ysyx_22050019_dmem_slave.sv
// tb_ysyx_22050019_dmem_slave: directed and randomized checks of the data memory responder
module tb_ysyx_22050019_dmem_slave;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;
  logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  logic sel = 1'b0, tv_valid = 1'b0, tv_wen = 1'b0, tv_resp_ready = 1'b0;
  logic [63:0] tv_addr = '0, tv_wdata = '0;
  logic [7:0]  tv_wmask = '0;
  logic        o_req_ready, o_resp_valid, o_err;
  logic [63:0] o_rdata;
  int checks = 0, failures = 0;
  logic [63:0] refm [16];
  always #5 clk = ~clk;
  ysyx_22050019_dmem_slave_if a ();
  ysyx_22050019_dmem_slave_if b ();
  assign a.req_valid  = tv_valid & ~sel;
  assign b.req_valid  = tv_valid & sel;
  assign a.req_wen    = tv_wen;
  assign b.req_wen    = tv_wen;
  assign a.req_addr   = tv_addr;
  assign b.req_addr   = tv_addr;
  assign a.req_wdata  = tv_wdata;
  assign b.req_wdata  = tv_wdata;
  assign a.req_wmask  = tv_wmask;
  assign b.req_wmask  = tv_wmask;
  assign a.resp_ready = tv_resp_ready & ~sel;
  assign b.resp_ready = tv_resp_ready & sel;
  assign o_req_ready  = sel ? b.req_ready  : a.req_ready;
  assign o_resp_valid = sel ? b.resp_valid : a.resp_valid;
  assign o_rdata      = sel ? b.resp_rdata : a.resp_rdata;
  assign o_err        = sel ? b.resp_err   : a.resp_err;
  ysyx_22050019_dmem_slave #(.DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .rst(rst_a), .bus(a.slave));
  ysyx_22050019_dmem_slave #(.DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // one full transaction on the selected instance; bp = cycles of resp_ready=0 in RESP
  task automatic xact(input logic w, input logic [63:0] ad, input logic [63:0] wd,
                      input logic [7:0] m, input int bp,
                      output logic [63:0] rd, output logic er);
    int lat;
    logic [63:0] rd0;
    logic er0;
    @(negedge clk);
    tv_valid = 1'b1; tv_wen = w; tv_addr = ad; tv_wdata = wd; tv_wmask = m; tv_resp_ready = 1'b0;
    chk("req_ready_idle", 64'(o_req_ready), 64'd1);
    @(negedge clk);
    tv_valid = 1'b0;
    lat = 1;
    while (!o_resp_valid && lat < 20) begin
      chk("req_ready_busy", 64'(o_req_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), sel ? 64'd5 : 64'd3);
    rd0 = o_rdata;
    er0 = o_err;
    for (int k = 0; k < bp; k++) begin
      tv_valid = 1'($urandom % 2);
      chk("stall_req_ready", 64'(o_req_ready), 64'd0);
      chk("stall_valid", 64'(o_resp_valid), 64'd1);
      chk("stall_rdata", o_rdata, rd0);
      chk("stall_err", 64'(o_err), 64'(er0));
      @(negedge clk);
    end
    tv_valid = 1'b0;
    tv_resp_ready = 1'b1;
    chk("hs_valid", 64'(o_resp_valid), 64'd1);
    @(negedge clk);
    tv_resp_ready = 1'b0;
    chk("post_valid", 64'(o_resp_valid), 64'd0);
    chk("post_req_ready", 64'(o_req_ready), 64'd1);
    chk("post_rdata", o_rdata, 64'd0);
    chk("post_err", 64'(o_err), 64'd0);
    rd = rd0;
    er = er0;
  endtask
  initial begin
    logic [63:0] rd, ad, wd, exp;
    logic er;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_req_ready", 64'(o_req_ready), 64'd1);
      chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
      chk("rst_rdata", o_rdata, 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
    end
    sel = 1'b0;
    xact(1, BASE, 64'h1122334455667788, 8'hFF, 0, rd, er);
    chk("pre0_rd", rd, 64'd0); chk("pre0_err", 64'(er), 64'd0);
    xact(0, BASE, 64'd0, 8'h00, 0, rd, er);
    chk("ld0_rd", rd, 64'h1122334455667788); chk("ld0_err", 64'(er), 64'd0);
    xact(1, BASE + 8, 64'd0, 8'hFF, 0, rd, er);
    xact(1, BASE + 8, 64'hAABBCCDDEEFF0011, 8'h0F, 0, rd, er);
    chk("st1_rd", rd, 64'd0); chk("st1_err", 64'(er), 64'd0);
    xact(0, BASE + 8, 64'd0, 8'h00, 0, rd, er);
    chk("ld1_merge", rd, 64'h00000000EEFF0011);
    xact(1, BASE + 8, '1, 8'h00, 0, rd, er);
    chk("st_nomask_err", 64'(er), 64'd0);
    xact(0, BASE + 8, 64'd0, 8'h00, 0, rd, er);
    chk("ld1_nomask", rd, 64'h00000000EEFF0011);
    xact(1, BASE + 64'(8 * (DEPTH - 1)), 64'hDEADBEEF0BADF00D, 8'hFF, 0, rd, er);
    xact(0, BASE + 64'(8 * DEPTH), 64'd0, 8'h00, 0, rd, er);
    chk("oor_hi_rd", rd, 64'd0); chk("oor_hi_err", 64'(er), 64'd1);
    xact(0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, rd, er);
    chk("oor_lo_rd", rd, 64'd0); chk("oor_lo_err", 64'(er), 64'd1);
    xact(1, BASE + 64'(8 * DEPTH), 64'h5555555555555555, 8'hFF, 0, rd, er);
    chk("oor_st_hi_err", 64'(er), 64'd1);
    xact(1, 64'h7FFF_FFF8, 64'h6666666666666666, 8'hFF, 0, rd, er);
    chk("oor_st_lo_err", 64'(er), 64'd1);
    xact(0, BASE, 64'd0, 8'h00, 0, rd, er);
    chk("oor_keep0", rd, 64'h1122334455667788);
    xact(0, BASE + 8, 64'd0, 8'h00, 0, rd, er);
    chk("oor_keep1", rd, 64'h00000000EEFF0011);
    xact(0, BASE + 64'(8 * (DEPTH - 1)), 64'd0, 8'h00, 0, rd, er);
    chk("oor_keep_last", rd, 64'hDEADBEEF0BADF00D);
    xact(0, BASE + 3, 64'd0, 8'h00, 5, rd, er);
    chk("bp_rd", rd, 64'h1122334455667788); chk("bp_err", 64'(er), 64'd0);
    sel = 1'b1;
    xact(1, BASE + 24, 64'h0123456789ABCDEF, 8'hFF, 0, rd, er);
    @(negedge clk);
    tv_valid = 1'b1; tv_wen = 1'b1; tv_addr = BASE + 24; tv_wdata = 64'hFFFF0000FFFF0000; tv_wmask = 8'hFF;
    @(negedge clk);
    tv_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("midrst_req_ready", 64'(o_req_ready), 64'd1);
    chk("midrst_resp_valid", 64'(o_resp_valid), 64'd0);
    repeat (6) @(negedge clk);
    chk("midrst_no_resp", 64'(o_resp_valid), 64'd0);
    xact(0, BASE + 24, 64'd0, 8'h00, 0, rd, er);
    chk("midrst_ld3", rd, 64'h0123456789ABCDEF);
    sel = 1'b0;
    for (int w = 0; w < 16; w++) begin
      refm[w] = {$urandom, $urandom};
      xact(1, BASE + 64'(8 * w), refm[w], 8'hFF, 0, rd, er);
    end
    for (int n = 0; n < 100; n++) begin
      int w;
      logic st, oor;
      logic [7:0] m;
      w   = $urandom_range(0, 15);
      st  = 1'($urandom % 2);
      oor = ($urandom % 8) == 0;
      wd  = {$urandom, $urandom};
      m   = 8'($urandom);
      if (oor) ad = ($urandom % 2) ? BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 100)) * 8
                                   : BASE - 64'($urandom_range(1, 100)) * 8;
      else ad = BASE + 64'(8 * w);
      ad[2:0] = 3'($urandom);
      xact(st, ad, wd, m, $urandom_range(0, 3), rd, er);
      exp = (oor || st) ? 64'd0 : refm[w];
      chk("rnd_rdata", rd, exp);
      chk("rnd_err", 64'(er), 64'(oor));
      if (st && !oor)
        for (int k = 0; k < 8; k++)
          if (m[k]) refm[w][8*k +: 8] = wd[8*k +: 8];
    end
    for (int w = 0; w < 16; w++) begin
      xact(0, BASE + 64'(8 * w), 64'd0, 8'h00, 0, rd, er);
      chk("final_word", rd, refm[w]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
